// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the instruction-fetch stage and its neighbours:
// the hazard/branch inputs from ID, the instruction memory port and the
// IF/ID pipeline register outputs. The fetch stage uses the master view,
// and everything around it (ID stage, memory, bench) uses the slave view.
interface if_fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        redirect_pending;
    logic [31:0] stall_cycles;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
               redirect_pending, stall_cycles
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
               redirect_pending, stall_cycles
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID register. Freezes under ID stalls, buffers a redirect that
// arrives during a stall, and counts stalled cycles (saturating).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_stage_if.master bus
);

    // Without a delay slot the instruction fetched alongside a redirect is
    // on the wrong path and has to become a bubble.
    localparam bit FLUSH_ON_REDIRECT = (DELAY_SLOT == 0);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifIdPc_q, ifIdPc_d;
    logic [31:0] ifIdPc4_q, ifIdPc4_d;
    logic [31:0] ifIdInstr_q, ifIdInstr_d;
    logic        ifIdValid_q, ifIdValid_d;
    logic        pending_q, pending_d;
    logic [31:0] pendTarget_q, pendTarget_d;
    logic [31:0] stallCnt_q, stallCnt_d;

    logic [31:0] pcPlus4;
    logic [31:0] alignedTarget;
    logic        redirect;

    assign pcPlus4       = pc_q + 32'd4;
    assign alignedTarget = bus.branch_target & ~32'h0000_0003;

    // Next-state selection: a stall freezes everything except redirect
    // buffering and the stall counter; otherwise a live redirect beats a
    // buffered one, which beats sequential fetch.
    always_comb begin
        pc_d         = pc_q;
        ifIdPc_d     = ifIdPc_q;
        ifIdPc4_d    = ifIdPc4_q;
        ifIdInstr_d  = ifIdInstr_q;
        ifIdValid_d  = ifIdValid_q;
        pending_d    = pending_q;
        pendTarget_d = pendTarget_q;
        stallCnt_d   = stallCnt_q;
        redirect     = 1'b0;

        if (bus.stall) begin
            if (bus.branch_taken) begin
                pending_d    = 1'b1;
                pendTarget_d = alignedTarget;
            end
            if (stallCnt_q != 32'hFFFF_FFFF) begin
                stallCnt_d = stallCnt_q + 32'd1;
            end
        end else begin
            if (bus.branch_taken) begin
                pc_d     = alignedTarget;
                redirect = 1'b1;
            end else if (pending_q) begin
                pc_d     = pendTarget_q;
                redirect = 1'b1;
            end else begin
                pc_d = pcPlus4;
            end
            pending_d = 1'b0;

            ifIdPc_d  = pc_q;
            ifIdPc4_d = pcPlus4;
            if (redirect && FLUSH_ON_REDIRECT) begin
                ifIdInstr_d = NOP_INSTR;
                ifIdValid_d = 1'b0;
            end else begin
                ifIdInstr_d = bus.imem_rdata;
                ifIdValid_d = 1'b1;
            end
        end
    end

    // State registers; reset lands immediately so a stalled or redirecting
    // pipeline returns to a clean fetch from RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifIdPc_q     <= 32'h0;
            ifIdPc4_q    <= 32'h0;
            ifIdInstr_q  <= NOP_INSTR;
            ifIdValid_q  <= 1'b0;
            pending_q    <= 1'b0;
            pendTarget_q <= 32'h0;
            stallCnt_q   <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            ifIdPc_q     <= ifIdPc_d;
            ifIdPc4_q    <= ifIdPc4_d;
            ifIdInstr_q  <= ifIdInstr_d;
            ifIdValid_q  <= ifIdValid_d;
            pending_q    <= pending_d;
            pendTarget_q <= pendTarget_d;
            stallCnt_q   <= stallCnt_d;
        end
    end

    assign bus.imem_addr        = pc_q;
    assign bus.if_id_pc         = ifIdPc_q;
    assign bus.if_id_pc4        = ifIdPc4_q;
    assign bus.if_id_instr      = ifIdInstr_q;
    assign bus.if_id_valid      = ifIdValid_q;
    assign bus.redirect_pending = pending_q;
    assign bus.stall_cycles     = stallCnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a delay-slot and a flushing instance share one
// stimulus stream; a reference model pushes expected post-edge state into a
// queue and a separate monitor pops and compares on each falling edge.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifIdPc;
        logic [31:0] ifIdPc4;
        logic [31:0] dsInstr;
        logic        dsValid;
        logic [31:0] flInstr;
        logic        flValid;
        logic        pending;
        logic [31:0] stallCnt;
    } expT;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;

    int checkCount;
    int errorCount;

    expT expQ[$];
    expT monExp;

    // Reference model state
    logic [31:0] mPc;
    logic        mPend;
    logic [31:0] mPendTarget;
    logic [31:0] mStallCnt;
    expT         mOut;

    if_fetch_stage_if busDs ();
    if_fetch_stage_if busFl ();

    // Instruction memory contents: a fixed scramble of the address so each
    // fetched word identifies where it came from.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign busDs.stall         = stall;
    assign busDs.branch_taken  = branchTaken;
    assign busDs.branch_target = branchTarget;
    assign busDs.imem_rdata    = rom(busDs.imem_addr);
    assign busFl.stall         = stall;
    assign busFl.branch_taken  = branchTaken;
    assign busFl.branch_target = branchTarget;
    assign busFl.imem_rdata    = rom(busFl.imem_addr);

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .DELAY_SLOT(1)) dutDs (
        .clk (clk),
        .rst (rst),
        .bus (busDs.master)
    );

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .DELAY_SLOT(0)) dutFl (
        .clk (clk),
        .rst (rst),
        .bus (busFl.master)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc         = RESET_PC;
        mPend       = 1'b0;
        mPendTarget = 32'h0;
        mStallCnt   = 32'h0;
        mOut.pc       = RESET_PC;
        mOut.ifIdPc   = 32'h0;
        mOut.ifIdPc4  = 32'h0;
        mOut.dsInstr  = NOP_INSTR;
        mOut.dsValid  = 1'b0;
        mOut.flInstr  = NOP_INSTR;
        mOut.flValid  = 1'b0;
        mOut.pending  = 1'b0;
        mOut.stallCnt = 32'h0;
    endtask

    // One pipeline cycle of the architectural behaviour.
    task automatic modelStep(input logic s, input logic bt, input logic [31:0] tg);
        logic        redirected;
        logic [31:0] nextPc;
        if (s) begin
            if (bt) begin
                mPend       = 1'b1;
                mPendTarget = tg & ~32'h3;
            end
            if (mStallCnt != 32'hFFFF_FFFF) mStallCnt = mStallCnt + 1;
        end else begin
            redirected = bt || mPend;
            nextPc     = bt ? (tg & ~32'h3) : (mPend ? mPendTarget : mPc + 32'd4);
            mOut.ifIdPc  = mPc;
            mOut.ifIdPc4 = mPc + 32'd4;
            mOut.dsInstr = rom(mPc);
            mOut.dsValid = 1'b1;
            mOut.flInstr = redirected ? NOP_INSTR : rom(mPc);
            mOut.flValid = !redirected;
            mPend = 1'b0;
            mPc   = nextPc;
        end
        mOut.pc       = mPc;
        mOut.pending  = mPend;
        mOut.stallCnt = mStallCnt;
    endtask

    // Called just after a falling edge: drive inputs, predict, let one
    // rising edge happen, and return just after the following falling edge.
    task automatic applyStimulus(input logic s, input logic bt, input logic [31:0] tg);
        stall        = s;
        branchTaken  = bt;
        branchTarget = tg;
        modelStep(s, bt, tg);
        expQ.push_back(mOut);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " ds imem_addr"}, busDs.imem_addr, RESET_PC);
        checkOutput({tag, " fl imem_addr"}, busFl.imem_addr, RESET_PC);
        checkOutput({tag, " ds if_id_pc"}, busDs.if_id_pc, 32'h0);
        checkOutput({tag, " ds if_id_pc4"}, busDs.if_id_pc4, 32'h0);
        checkOutput({tag, " ds if_id_instr"}, busDs.if_id_instr, NOP_INSTR);
        checkOutput({tag, " ds if_id_valid"}, {31'h0, busDs.if_id_valid}, 32'h0);
        checkOutput({tag, " fl if_id_valid"}, {31'h0, busFl.if_id_valid}, 32'h0);
        checkOutput({tag, " ds redirect_pending"}, {31'h0, busDs.redirect_pending}, 32'h0);
        checkOutput({tag, " fl redirect_pending"}, {31'h0, busFl.redirect_pending}, 32'h0);
        checkOutput({tag, " ds stall_cycles"}, busDs.stall_cycles, 32'h0);
        checkOutput({tag, " fl stall_cycles"}, busFl.stall_cycles, 32'h0);
    endtask

    // Monitor: whenever a prediction is waiting, compare both instances on
    // the falling edge that follows the rising edge it describes.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("ds imem_addr", busDs.imem_addr, monExp.pc);
                checkOutput("fl imem_addr", busFl.imem_addr, monExp.pc);
                checkOutput("ds if_id_pc", busDs.if_id_pc, monExp.ifIdPc);
                checkOutput("fl if_id_pc", busFl.if_id_pc, monExp.ifIdPc);
                checkOutput("ds if_id_pc4", busDs.if_id_pc4, monExp.ifIdPc4);
                checkOutput("fl if_id_pc4", busFl.if_id_pc4, monExp.ifIdPc4);
                checkOutput("ds if_id_instr", busDs.if_id_instr, monExp.dsInstr);
                checkOutput("fl if_id_instr", busFl.if_id_instr, monExp.flInstr);
                checkOutput("ds if_id_valid", {31'h0, busDs.if_id_valid}, {31'h0, monExp.dsValid});
                checkOutput("fl if_id_valid", {31'h0, busFl.if_id_valid}, {31'h0, monExp.flValid});
                checkOutput("ds redirect_pending", {31'h0, busDs.redirect_pending}, {31'h0, monExp.pending});
                checkOutput("fl redirect_pending", {31'h0, busFl.redirect_pending}, {31'h0, monExp.pending});
                checkOutput("ds stall_cycles", busDs.stall_cycles, monExp.stallCnt);
                checkOutput("fl stall_cycles", busFl.stall_cycles, monExp.stallCnt);
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        checkCount   = 0;
        errorCount   = 0;
        rst          = 1'b1;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        modelReset();
        #3;
        checkReset("power-on");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // Sequential fetch up to pc 0040_0010
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        // Two stall cycles, then resume to pc 0040_0020
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        // Live branch at pc 0040_0020
        applyStimulus(1'b0, 1'b1, 32'h0040_0100);
        applyStimulus(1'b0, 1'b0, 32'h0);
        // Redirect buffered during a stall
        applyStimulus(1'b1, 1'b1, 32'h0040_0200);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        // Latest buffered redirect wins
        applyStimulus(1'b1, 1'b1, 32'h0040_0200);
        applyStimulus(1'b1, 1'b1, 32'h0040_0300);
        applyStimulus(1'b0, 1'b0, 32'h0);
        // Live redirect on release overrides the buffered one
        applyStimulus(1'b1, 1'b1, 32'h0040_0200);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0040_0400);
        applyStimulus(1'b0, 1'b0, 32'h0);
        // Misaligned target and PC wrap-around
        applyStimulus(1'b0, 1'b1, 32'h0040_0103);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Stall counter saturation
        force dutDs.stallCnt_q = 32'hFFFF_FFFE;
        force dutFl.stallCnt_q = 32'hFFFF_FFFE;
        #1;
        release dutDs.stallCnt_q;
        release dutFl.stallCnt_q;
        mStallCnt = 32'hFFFF_FFFE;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset while stalled with a redirect pending
        applyStimulus(1'b1, 1'b1, 32'h0080_0000);
        rst = 1'b1;
        #1;
        checkReset("mid-stall");
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        stall = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic        bt;
            logic [31:0] tg;
            s  = ($urandom_range(0, 2) == 0);
            bt = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       tg = $urandom;
                1:       tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: tg = RESET_PC + ($urandom & 32'h0000_0FFF);
            endcase
            applyStimulus(s, bt, tg);
        end

        checkOutput("queue drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
